// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. One full-adder bit slice plus a registered
//   carry adds the operands LSB-first, one bit per clock. The result lands in
//   sum/cout on the completing edge, and done pulses for one cycle after that.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      begin an addition (only honoured in IDLE)
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high in SHIFT and DONE
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered final carry, held with sum
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_a_next;

    // Full-adder bit slice
    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // The A register doubles as the result shift register: each consumed
    // operand bit leaves at the LSB while the new sum bit enters at the MSB,
    // so after WIDTH shifts it holds the complete sum.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_a_next = w_s;
        end else begin : g_wn
            assign w_a_next = {w_s, r_a[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a     <= w_a_next;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    // Outputs only move here, so partial results never show.
                    if (r_cnt == LAST) begin
                        r_sum   <= w_a_next;
                        r_cout  <= w_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout;

    // WIDTH=1 build shares clock and reset
    logic       s1_start;
    logic [0:0] s1_a, s1_b;
    logic       s1_cin;
    logic       s1_busy, s1_done;
    logic [0:0] s1_sum;
    logic       s1_cout;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation on the WIDTH=8 DUT. Checks the done latency, that
    // busy stays high and the previous result is held through SHIFT, the
    // result itself, and that done drops after one cycle.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                         input logic [7:0] esum, input logic ecout);
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         n;
        prev_sum  = sum;
        prev_cout = cout;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 0;
        while (!done && n < 40) begin
            chk("busy_in_shift", 32'(busy), 32'd1);
            chk("sum_hold", {23'd0, prev_cout, prev_sum}, {23'd0, cout, sum});
            @(negedge clk);
            n++;
        end
        chk("done_latency", n, 8);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("sum", 32'(sum), 32'(esum));
        chk("cout", 32'(cout), 32'(ecout));
        @(negedge clk);
        chk("done_pulse_end", {busy, done}, 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        logic [8:0] ref9;
        logic [7:0] ra, rb;
        logic       rc;
        int         n, gap;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        tbl[1] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {busy, done, cout, sum}, 32'd0);
        chk("reset_state_w1", {s1_busy, s1_done, s1_cout, s1_sum}, 32'd0);

        // Table vectors: entry 1 runs right after 0x7F is produced, so the
        // hold check inside do_op covers "0x7F held during SHIFT".
        for (int i = 0; i < 7; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp_sum, tbl[i].exp_cout);

        // Random operands against plain arithmetic
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op(ra, rb, rc, ref9[7:0], ref9[8]);
        end

        // start held high: back-to-back ops, start mid-SHIFT ignored
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        chk("b2b_first_sum", {cout, sum}, 32'h002);
        a = 8'h02; b = 8'h02;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 4) begin a = 8'hAA; b = 8'h55; end
        end while (!done && gap < 40);
        chk("b2b_gap", gap, 10);
        chk("b2b_second_sum", {cout, sum}, 32'h004);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {busy, done}, 32'd0);

        // Reset after the 4th SHIFT of 0xF0+0x0F discards the operation
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_state", {busy, done, cout, sum}, 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("no_done_after_reset", n, 0);
        do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

        // WIDTH=1 build, exhaustive against arithmetic
        for (int v = 7; v >= 0; v--) begin
            logic [1:0] r2;
            logic [2:0] vv;
            vv = 3'(v);
            r2 = {1'b0, vv[2]} + {1'b0, vv[1]} + {1'b0, vv[0]};
            @(negedge clk);
            s1_a = vv[2]; s1_b = vv[1]; s1_cin = vv[0]; s1_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s1_start = 1'b0;
            n = 0;
            while (!s1_done && n < 10) begin
                chk("w1_busy", 32'(s1_busy), 32'd1);
                @(negedge clk);
                n++;
            end
            chk("w1_latency", n, 1);
            chk("w1_result", {s1_cout, s1_sum}, 32'(r2));
            @(negedge clk);
            chk("w1_idle", {s1_busy, s1_done}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
